// File: rtl/raven_gpio_ctrl.sv
// GPIO controller for the Raven pad bank: iomem slave with output/enable registers,
// synchronised input readback and per-pin edge interrupts folded into one irq line.
module raven_gpio_ctrl #(
  parameter int unsigned NGPIO     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq
);

  localparam int unsigned WORDW = 6;

  localparam logic [WORDW-1:0] W_OUT   = WORDW'(0);
  localparam logic [WORDW-1:0] W_OE    = WORDW'(1);
  localparam logic [WORDW-1:0] W_IN    = WORDW'(2);
  localparam logic [WORDW-1:0] W_IMASK = WORDW'(3);
  localparam logic [WORDW-1:0] W_IPOL  = WORDW'(4);
  localparam logic [WORDW-1:0] W_ISTAT = WORDW'(5);
  localparam logic [WORDW-1:0] W_OSET  = WORDW'(6);
  localparam logic [WORDW-1:0] W_OCLR  = WORDW'(7);

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state;
  logic [NGPIO-1:0] out_q, oe_q, imask_q, ipol_q, istat_q;
  logic [NGPIO-1:0] s1_q, s2_q, s3_q;

  logic             sel_c, acc_c, wr_c;
  logic [WORDW-1:0] word_c;
  logic [31:0]      bm32_c;
  logic [NGPIO-1:0] bm_c, wd_c, evt_c, w1c_c;
  logic [31:0]      rd_c;
  logic             unused_c;

  assign sel_c  = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc_c  = (state == IDLE) && sel_c && !iomem_ready;
  assign wr_c   = acc_c && (|iomem_wstrb);
  assign word_c = iomem_addr[7:2];

  // Byte strobes widened to bit enables, truncated to the implemented pins
  assign bm32_c = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign bm_c   = bm32_c[NGPIO-1:0];
  assign wd_c   = iomem_wdata[NGPIO-1:0] & bm_c;

  assign evt_c  = (ipol_q & s2_q & ~s3_q) | (~ipol_q & ~s2_q & s3_q);
  assign w1c_c  = (wr_c && (word_c == W_ISTAT)) ? wd_c : '0;

  assign unused_c = ^{iomem_addr[1:0], iomem_wdata, bm32_c};

  always_comb begin
    rd_c = '0;
    case (word_c)
      W_OUT:   rd_c[NGPIO-1:0] = out_q;
      W_OE:    rd_c[NGPIO-1:0] = oe_q;
      W_IN:    rd_c[NGPIO-1:0] = s2_q;
      W_IMASK: rd_c[NGPIO-1:0] = imask_q;
      W_IPOL:  rd_c[NGPIO-1:0] = ipol_q;
      W_ISTAT: rd_c[NGPIO-1:0] = istat_q;
      default: rd_c = '0;
    endcase
  end

  // Bus handshake: one-cycle ready with read data captured at acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_c) begin
            state       <= ACK;
            iomem_ready <= 1'b1;
            iomem_rdata <= rd_c;
          end else begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
          end
        end
        ACK: begin
          state       <= IDLE;
          iomem_ready <= 1'b0;
          iomem_rdata <= '0;
        end
        default: begin
          state       <= IDLE;
          iomem_ready <= 1'b0;
          iomem_rdata <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q   <= '0;
      oe_q    <= '0;
      imask_q <= '0;
      ipol_q  <= '0;
    end else if (wr_c) begin
      case (word_c)
        W_OUT:   out_q   <= (out_q & ~bm_c) | wd_c;
        W_OE:    oe_q    <= (oe_q & ~bm_c) | wd_c;
        W_IMASK: imask_q <= (imask_q & ~bm_c) | wd_c;
        W_IPOL:  ipol_q  <= (ipol_q & ~bm_c) | wd_c;
        W_OSET:  out_q   <= out_q | wd_c;
        W_OCLR:  out_q   <= out_q & ~wd_c;
        default: ;
      endcase
    end
  end

  // Pad synchroniser, edge capture (set beats clear) and registered irq
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      istat_q <= '0;
      irq     <= 1'b0;
    end else begin
      s1_q    <= gpio_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      istat_q <= (istat_q & ~w1c_c) | evt_c;
      irq     <= |(istat_q & imask_q);
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_raven_gpio_ctrl.sv
// Randomised bench for raven_gpio_ctrl against a cycle-level behavioural model of the
// register map, bus handshake and pad edge history.
module tb_raven_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  raven_gpio_ctrl #(.NGPIO(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference state; h[k] is the pad value sampled k+1 edges ago
  logic [15:0] m_out, m_oe, m_imask, m_ipol, m_istat;
  logic [15:0] h [3];
  logic        m_ready, m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_imask = '0; m_ipol = '0; m_istat = '0;
    h[0] = '0; h[1] = '0; h[2] = '0;
    m_ready = 1'b0; m_irq = 1'b0; m_rdata = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] o;
    o = {a[7:2], 2'b00};
    case (o)
      8'h00:   return {16'h0, m_out};
      8'h04:   return {16'h0, m_oe};
      8'h08:   return {16'h0, h[1]};
      8'h0C:   return {16'h0, m_imask};
      8'h10:   return {16'h0, m_ipol};
      8'h14:   return {16'h0, m_istat};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] bm, wd, w1c, rise, fall, evt;
    logic [15:0] n_out, n_oe, n_imask, n_ipol;
    logic [7:0]  o;
    logic        n_ready;
    logic [31:0] n_rdata;
    n_out = m_out; n_oe = m_oe; n_imask = m_imask; n_ipol = m_ipol;
    n_ready = 1'b0; n_rdata = '0; w1c = '0;
    bm = {{8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    wd = iomem_wdata[15:0] & bm;
    o  = {iomem_addr[7:2], 2'b00};
    if (!m_ready && iomem_valid && iomem_addr[31:8] == BASE[31:8]) begin
      n_ready = 1'b1;
      n_rdata = m_read(iomem_addr);
      if (iomem_wstrb != 4'b0) begin
        case (o)
          8'h00: n_out   = (m_out & ~bm) | wd;
          8'h04: n_oe    = (m_oe & ~bm) | wd;
          8'h0C: n_imask = (m_imask & ~bm) | wd;
          8'h10: n_ipol  = (m_ipol & ~bm) | wd;
          8'h14: w1c     = wd;
          8'h18: n_out   = m_out | wd;
          8'h1C: n_out   = m_out & ~wd;
          default: ;
        endcase
      end
    end
    rise = h[1] & ~h[2];
    fall = ~h[1] & h[2];
    evt  = (m_ipol & rise) | (~m_ipol & fall);
    m_irq   = |(m_istat & m_imask);
    m_istat = (m_istat & ~w1c) | evt;
    m_out = n_out; m_oe = n_oe; m_imask = n_imask; m_ipol = n_ipol;
    m_ready = n_ready; m_rdata = n_rdata;
    h[2] = h[1]; h[1] = h[0]; h[0] = gpio_in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
    check("ready", {31'h0, iomem_ready}, {31'h0, m_ready});
    check("rdata", iomem_rdata, m_rdata);
    check("gpio_out", {16'h0, gpio_out}, {16'h0, m_out});
    check("gpio_oe", {16'h0, gpio_oe}, {16'h0, m_oe});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd);
    logic seen;
    logic want;
    seen = 1'b0;
    want = (a[31:8] == BASE[31:8]);
    rd = '0;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (iomem_ready) begin
        seen = 1'b1;
        rd = iomem_rdata;
      end
    end
    check("bus_ack", {31'h0, seen}, {31'h0, want});
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    bus(BASE + 32'(off), s, d, dummy);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    bus(BASE + 32'(off), 4'h0, 32'h0, r);
  endtask

  logic [31:0] r;
  logic        seen;
  logic [7:0]  off;
  logic [3:0]  strb;

  initial begin
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = '0; iomem_wdata = '0; gpio_in = '0;
    model_reset();
    #1;
    check("rst_out", {16'h0, gpio_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    wr(8'h04, 4'hF, 32'h0000_00FF);
    check("oe_write", {16'h0, gpio_oe}, 32'h0000_00FF);
    wr(8'h00, 4'hF, 32'h0000_A5A5);
    check("out_write", {16'h0, gpio_out}, 32'h0000_A5A5);
    rd(8'h04, r); check("oe_read", r, 32'h0000_00FF);
    rd(8'h00, r); check("out_read", r, 32'h0000_A5A5);
    tick();
    check("ready_one_cycle", {31'h0, iomem_ready}, 32'h0);

    wr(8'h00, 4'b0010, 32'h0000_1234);
    check("byte_strobe", {16'h0, gpio_out}, 32'h0000_12A5);
    wr(8'h18, 4'hF, 32'h0000_0003);
    check("oset", {16'h0, gpio_out}, 32'h0000_12A7);
    wr(8'h1C, 4'hF, 32'h0000_0080);
    check("oclr", {16'h0, gpio_out}, 32'h0000_1227);

    wr(8'h10, 4'hF, 32'h1);
    wr(8'h0C, 4'hF, 32'h1);
    gpio_in = 16'h0001;
    tick(); tick();
    rd(8'h08, r); check("in_sync", r, 32'h1);
    rd(8'h14, r); check("istat_rise", r, 32'h1);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(8'h14, 4'hF, 32'h1);
    tick();
    check("irq_clear", {31'h0, irq}, 32'h0);
    gpio_in = 16'h0000;
    repeat (4) tick();
    rd(8'h14, r); check("fall_ignored", r, 32'h0);

    wr(8'h10, 4'hF, 32'h9);
    gpio_in = 16'h0008;
    tick(); tick();
    wr(8'h14, 4'hF, 32'h8);
    rd(8'h14, r); check("set_beats_clear", r, 32'h8);

    wr(8'h40, 4'hF, 32'hFFFF);
    check("unmapped_write", {16'h0, gpio_out}, 32'h0000_1227);
    rd(8'h40, r); check("unmapped_read", r, 32'h0);
    bus(BASE + 32'h100, 4'h0, 32'h0, r);

    // Reset asserted while the bus is in its acknowledge cycle
    iomem_valid = 1'b1; iomem_addr = BASE; iomem_wstrb = 4'hF; iomem_wdata = 32'h5A5A;
    tick();
    check("pre_rst_ready", {31'h0, iomem_ready}, 32'h1);
    resetn = 1'b0;
    #1;
    check("rst_ack_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_ack_out", {16'h0, gpio_out}, 32'h0);
    model_reset();
    tick();
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (iomem_ready) seen = 1'b1;
    end
    check("post_rst_ack", {31'h0, seen}, 32'h1);
    check("post_rst_out", {16'h0, gpio_out}, 32'h0000_5A5A);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;

    repeat (500) begin
      if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ 16'(1 << $urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: tick();
        default: begin
          off  = 8'(4 * $urandom_range(0, 8));
          if ($urandom_range(0, 9) == 0) off = 8'h40;
          strb = 4'($urandom);
          if ($urandom_range(0, 1) == 0) strb = 4'h0;
          if ($urandom_range(0, 29) == 0) bus(BASE + 32'h200, strb, $urandom, r);
          else bus(BASE + 32'(off), strb, $urandom, r);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
